// File: rtl/piso_tx_scheduler.sv
// Round-robin shared serializer: grants one of NUM_REQ word producers and shifts
// the accepted word out MSB-first with valid/last framing and an optional idle gap.
//
// state   | meaning
// S_IDLE  | no word in flight; req_ready offers a round-robin grant
// S_SHIFT | word bits leaving MSB-first; hold freezes the shifter
// S_GAP   | GAP_CYCLES forced idle cycles after the final bit
module piso_tx_scheduler #(
  parameter int WIDTH      = 4,
  parameter int NUM_REQ    = 2,
  parameter int GAP_CYCLES = 1,
  localparam int SRC_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic                     hold,
  output logic                     serial_out,
  output logic                     serial_valid,
  output logic                     serial_last,
  output logic [SRC_W-1:0]         serial_src,
  output logic                     busy
);

  localparam int CW = $clog2(WIDTH);
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_GAP} state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   shreg_q, shreg_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [GW-1:0]      gap_q, gap_d;
  logic [SRC_W-1:0]   last_grant_q, last_grant_d;

  logic               grant_found;
  logic [SRC_W-1:0]   grant_idx;
  logic [SRC_W:0]     scan_sum;
  logic [SRC_W-1:0]   scan_idx;
  logic [WIDTH-1:0]   grant_word;

  // Search starts one past the previous winner so every requester gets a turn.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    scan_sum    = '0;
    scan_idx    = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      scan_sum = {1'b0, last_grant_q} + (SRC_W+1)'(k);
      if (scan_sum >= (SRC_W+1)'(NUM_REQ))
        scan_sum = scan_sum - (SRC_W+1)'(NUM_REQ);
      scan_idx = scan_sum[SRC_W-1:0];
      if (!grant_found && req_valid[scan_idx]) begin
        grant_found = 1'b1;
        grant_idx   = scan_idx;
      end
    end
  end

  always_comb begin
    grant_word = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_idx == SRC_W'(i))
        grant_word = req_data[i*WIDTH +: WIDTH];
    end
  end

  // Grant is withheld while reset is asserted even though the state reads IDLE.
  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_ready[i] = reset && (state_q == S_IDLE) && grant_found &&
                     (grant_idx == SRC_W'(i));
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      shreg_q      <= '0;
      cnt_q        <= '0;
      gap_q        <= '0;
      last_grant_q <= SRC_W'(NUM_REQ-1);
    end else begin
      state_q      <= state_d;
      shreg_q      <= shreg_d;
      cnt_q        <= cnt_d;
      gap_q        <= gap_d;
      last_grant_q <= last_grant_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    shreg_d      = shreg_q;
    cnt_d        = cnt_q;
    gap_d        = gap_q;
    last_grant_d = last_grant_q;
    case (state_q)
      S_IDLE: begin
        if (grant_found) begin
          shreg_d      = grant_word;
          last_grant_d = grant_idx;
          cnt_d        = CW'(WIDTH-1);
          state_d      = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (!hold) begin
          shreg_d = shreg_q << 1;
          cnt_d   = cnt_q - 1'b1;
          if (cnt_q == '0) begin
            cnt_d = '0;
            if (GAP_CYCLES == 0) begin
              state_d = S_IDLE;
            end else begin
              gap_d   = GW'(GAP_CYCLES-1);
              state_d = S_GAP;
            end
          end
        end
      end
      S_GAP: begin
        if (gap_q == '0)
          state_d = S_IDLE;
        else
          gap_d = gap_q - 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    serial_valid = (state_q == S_SHIFT) && !hold;
    serial_out   = serial_valid && shreg_q[WIDTH-1];
    serial_last  = serial_valid && (cnt_q == '0);
    serial_src   = (state_q == S_SHIFT) ? last_grant_q : '0;
    busy         = (state_q != S_IDLE);
  end

endmodule
